// File: rtl/regfile_cmd_ctrl.sv
// regfile_cmd_ctrl: command-driven initiator for a 2-read/1-write register file.
module regfile_cmd_ctrl #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_a,
    input  logic [AW-1:0]    cmd_b,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data0,
    output logic [WIDTH-1:0] resp_data1,
    output logic             resp_last,
    output logic             busy,
    output logic             we3,
    output logic [AW-1:0]    wa3,
    output logic [WIDTH-1:0] wd3,
    output logic [AW-1:0]    ra1,
    output logic [AW-1:0]    ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CP, S_CLR, S_DMP} state_t;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [AW-1:0] LAST_BEAT = {1'b0, {(AW-1){1'b1}}};
    state_t state_q, state_d;
    logic [AW-1:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic we;
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        data_d = data_q;
        cnt_d = cnt_q;
        we = 1'b0;
        wa3 = '0;
        wd3 = '0;
        ra1 = '0;
        ra2 = '0;
        resp_valid = 1'b0;
        resp_last = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready) begin
                a_d = cmd_a;
                b_d = cmd_b;
                data_d = cmd_data;
                cnt_d = (cmd_op == 3'b100) ? AW'(1) : '0;
                case (cmd_op)
                    3'b001:  state_d = S_WR;
                    3'b010:  state_d = S_RD;
                    3'b011:  state_d = S_CP;
                    3'b100:  state_d = S_CLR;
                    3'b101:  state_d = S_DMP;
                    default: state_d = S_IDLE;
                endcase
            end
            S_WR: begin
                we = 1'b1;
                wa3 = a_q;
                wd3 = data_q;
                state_d = S_IDLE;
            end
            S_RD: begin
                ra1 = a_q;
                ra2 = b_q;
                resp_valid = 1'b1;
                resp_last = 1'b1;
                state_d = resp_ready ? S_IDLE : S_RD;
            end
            S_CP: begin
                ra1 = b_q;
                we = 1'b1;
                wa3 = a_q;
                wd3 = rd1;
                state_d = S_IDLE;
            end
            S_CLR: begin
                we = 1'b1;
                wa3 = cnt_q;
                cnt_d = (cnt_q == LAST_ADDR) ? '0 : cnt_q + AW'(1);
                state_d = (cnt_q == LAST_ADDR) ? S_IDLE : S_CLR;
            end
            S_DMP: begin
                ra1 = {cnt_q[AW-2:0], 1'b0};
                ra2 = {cnt_q[AW-2:0], 1'b1};
                resp_valid = 1'b1;
                resp_last = (cnt_q == LAST_BEAT);
                if (resp_ready) begin
                    cnt_d = resp_last ? '0 : cnt_q + AW'(1);
                    state_d = resp_last ? S_IDLE : S_DMP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    // Gating with reset_n keeps a write from landing on the edge that aborts the operation.
    assign we3 = we & reset_n;
    assign cmd_ready = (state_q == S_IDLE) & reset_n;
    assign busy = (state_q != S_IDLE);
    assign resp_data0 = rd1;
    assign resp_data1 = rd2;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q <= '0;
            b_q <= '0;
            data_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            data_q <= data_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
